// File: rtl/step_cmd_ctrl_pkg.sv
// Shared types and constants for the step command controller and the step drivers.
package step_cmd_ctrl_pkg;

  // Per-axis controller state; the encoding is also visible to the step drivers.
  typedef enum logic [1:0] {
    StIdle      = 2'd0,
    StRun       = 2'd1,
    StLimitHold = 2'd2,
    StTimeout   = 2'd3
  } axis_state_e;

  // Direction values as seen by the step drivers.
  localparam bit DirFwd = 1'b0;
  localparam bit DirRev = 1'b1;

endpackage

// File: rtl/step_cmd_ctrl_if.sv
// Button/limit inputs and driver outputs for all axes of the step command controller.
interface step_cmd_ctrl_if #(
  parameter int unsigned NUM_AXES = 2
);

  logic                step_tick;
  logic [NUM_AXES-1:0] dir_btn;
  logic [NUM_AXES-1:0] run_btn;
  logic [NUM_AXES-1:0] limit;
  logic [NUM_AXES-1:0] dir;
  logic [NUM_AXES-1:0] en;
  logic [NUM_AXES-1:0] limit_hold;
  logic [NUM_AXES-1:0] timeout;

  // Stimulus side: buttons, switches and the step tick source.
  modport master (
    output step_tick, dir_btn, run_btn, limit,
    input  dir, en, limit_hold, timeout
  );

  // Controller side.
  modport slave (
    input  step_tick, dir_btn, run_btn, limit,
    output dir, en, limit_hold, timeout
  );

endinterface

// File: rtl/step_axis_ctrl.sv
// Single-axis command FSM: button edge detect, direction toggle, limit interlock, step timeout.
module step_axis_ctrl
  import step_cmd_ctrl_pkg::*;
#(
  parameter int unsigned STEP_CNT_W   = 16,
  parameter int unsigned MAX_STEPS    = 4000,
  parameter bit          TOWARD_LIMIT = DirRev,
  parameter bit          DIR_RESET    = DirFwd
) (
  input  logic clk,
  input  logic rst,
  input  logic step_tick,
  input  logic dir_btn,
  input  logic run_btn,
  input  logic limit,
  output logic dir,
  output logic en,
  output logic limit_hold,
  output logic timeout
);

  // Counter value on which the next tick ends the run.
  localparam logic [STEP_CNT_W-1:0] LastCnt =
      STEP_CNT_W'((MAX_STEPS == 0) ? 0 : MAX_STEPS - 1);

  axis_state_e           state_q, state_d;
  logic                  dir_q, dir_d;
  logic [STEP_CNT_W-1:0] cnt_q, cnt_d;
  logic                  dir_btn_q, run_btn_q;
  logic                  dir_rise, run_rise, blocked;

  assign dir_rise = dir_btn & ~dir_btn_q;
  assign run_rise = run_btn & ~run_btn_q;

  // State, direction, counter and button history; history resets high so held buttons are inert.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q   <= StIdle;
      dir_q     <= DIR_RESET;
      cnt_q     <= '0;
      dir_btn_q <= 1'b1;
      run_btn_q <= 1'b1;
    end else begin
      state_q   <= state_d;
      dir_q     <= dir_d;
      cnt_q     <= cnt_d;
      dir_btn_q <= dir_btn;
      run_btn_q <= run_btn;
    end
  end

  // Next state: blocked is judged on the post-toggle direction.
  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    dir_d   = dir_q ^ dir_rise;
    blocked = limit && (dir_d == TOWARD_LIMIT);
    unique case (state_q)
      StIdle: begin
        if (run_rise && !blocked) begin
          state_d = StRun;
          cnt_d   = '0;
        end
      end
      StRun: begin
        if (blocked) begin
          state_d = StLimitHold;
        end else if (run_rise) begin
          state_d = StIdle;
        end else if (dir_rise) begin
          // A reversal restarts the travel budget; a coincident tick is not counted.
          cnt_d = '0;
        end else if (step_tick) begin
          if ((MAX_STEPS != 0) && (cnt_q == LastCnt)) begin
            state_d = StTimeout;
          end else if (cnt_q != '1) begin
            cnt_d = cnt_q + 1'b1;
          end
        end
      end
      StLimitHold: begin
        // Released once the registered direction points away or the switch opens.
        if ((dir_q != TOWARD_LIMIT) || !limit) begin
          state_d = StIdle;
        end
      end
      StTimeout: begin
        if (run_rise) begin
          state_d = StIdle;
        end
      end
      default: state_d = StIdle;
    endcase
  end

  // Outputs decoded from the registered state.
  always_comb begin
    dir        = dir_q;
    en         = (state_q == StRun);
    limit_hold = (state_q == StLimitHold);
    timeout    = (state_q == StTimeout);
  end

endmodule

// File: rtl/step_cmd_ctrl.sv
// Multi-axis step command controller: one independent step_axis_ctrl per axis.
module step_cmd_ctrl
  import step_cmd_ctrl_pkg::*;
#(
  parameter int unsigned NUM_AXES     = 2,
  parameter int unsigned STEP_CNT_W   = 16,
  parameter int unsigned MAX_STEPS    = 4000,
  parameter bit          TOWARD_LIMIT = DirRev,
  parameter bit          DIR_RESET    = DirFwd
) (
  input  logic           clk,
  input  logic           rst,
  step_cmd_ctrl_if.slave bus
);

  // The timeout compare value must fit in the counter.
  if (64'(MAX_STEPS) >= (64'd1 << STEP_CNT_W)) begin : g_bad_max_steps
    $error("MAX_STEPS does not fit in STEP_CNT_W bits");
  end

  logic [NUM_AXES-1:0] dir_w;
  logic [NUM_AXES-1:0] en_w;
  logic [NUM_AXES-1:0] limit_hold_w;
  logic [NUM_AXES-1:0] timeout_w;

  for (genvar i = 0; i < NUM_AXES; i++) begin : g_axis
    step_axis_ctrl #(
      .STEP_CNT_W   (STEP_CNT_W),
      .MAX_STEPS    (MAX_STEPS),
      .TOWARD_LIMIT (TOWARD_LIMIT),
      .DIR_RESET    (DIR_RESET)
    ) u_axis (
      .clk        (clk),
      .rst        (rst),
      .step_tick  (bus.step_tick),
      .dir_btn    (bus.dir_btn[i]),
      .run_btn    (bus.run_btn[i]),
      .limit      (bus.limit[i]),
      .dir        (dir_w[i]),
      .en         (en_w[i]),
      .limit_hold (limit_hold_w[i]),
      .timeout    (timeout_w[i])
    );
  end

  assign bus.dir        = dir_w;
  assign bus.en         = en_w;
  assign bus.limit_hold = limit_hold_w;
  assign bus.timeout    = timeout_w;

endmodule

// File: tb/tb_step_cmd_ctrl.sv
// Directed bench for step_cmd_ctrl: a per-cycle vector table plus hand-written multi-cycle sequences.
module tb_step_cmd_ctrl;

  logic clk = 1'b0;
  logic rst = 1'b1;
  int   total = 0;
  int   bad   = 0;

  step_cmd_ctrl_if #(.NUM_AXES(2)) bus ();

  step_cmd_ctrl #(
    .NUM_AXES     (2),
    .STEP_CNT_W   (16),
    .MAX_STEPS    (5),
    .TOWARD_LIMIT (1'b1),
    .DIR_RESET    (1'b0)
  ) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic       rst;
    logic       tick;
    logic [1:0] dbtn;
    logic [1:0] rbtn;
    logic [1:0] lim;
    logic [1:0] e_dir;
    logic [1:0] e_en;
    logic [1:0] e_lh;
    logic [1:0] e_to;
  } vec_t;

  vec_t vecs[$];

  task automatic add(input logic r, input logic t, input logic [1:0] d, input logic [1:0] rb,
                     input logic [1:0] l, input logic [1:0] edir, input logic [1:0] een,
                     input logic [1:0] elh, input logic [1:0] eto);
    vec_t v;
    v = '{r, t, d, rb, l, edir, een, elh, eto};
    vecs.push_back(v);
  endtask

  task automatic chk(input string name, input logic [1:0] act, input logic [1:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %b expected %b at %0t", name, act, exp, $time);
    end
  endtask

  // Advance one clock and settle just after the edge.
  task automatic cyc();
    @(posedge clk);
    #1;
  endtask

  task automatic pulse_tick();
    bus.step_tick = 1'b1;
    cyc();
    bus.step_tick = 1'b0;
    cyc();
  endtask

  task automatic chk_all(input string tag, input logic [1:0] edir, input logic [1:0] een,
                         input logic [1:0] elh, input logic [1:0] eto);
    chk({tag, ".dir"}, bus.dir, edir);
    chk({tag, ".en"}, bus.en, een);
    chk({tag, ".limit_hold"}, bus.limit_hold, elh);
    chk({tag, ".timeout"}, bus.timeout, eto);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish, got timeout expected finish");
    $fatal(1, "watchdog");
  end

  initial begin
    bus.step_tick = 1'b0;
    bus.dir_btn   = 2'b00;
    bus.run_btn   = 2'b00;
    bus.limit     = 2'b00;

    //   rst tick dbtn   rbtn   lim    dir    en     lh     to
    add(1, 0, 2'b00, 2'b00, 2'b00, 2'b00, 2'b00, 2'b00, 2'b00);  // reset state
    add(0, 0, 2'b00, 2'b00, 2'b00, 2'b00, 2'b00, 2'b00, 2'b00);
    add(0, 0, 2'b00, 2'b01, 2'b00, 2'b00, 2'b01, 2'b00, 2'b00);  // run rise -> RUN
    add(0, 0, 2'b00, 2'b00, 2'b00, 2'b00, 2'b01, 2'b00, 2'b00);
    add(0, 0, 2'b00, 2'b01, 2'b00, 2'b00, 2'b00, 2'b00, 2'b00);  // second rise -> IDLE
    add(0, 0, 2'b00, 2'b00, 2'b00, 2'b00, 2'b00, 2'b00, 2'b00);
    add(0, 0, 2'b01, 2'b00, 2'b00, 2'b01, 2'b00, 2'b00, 2'b00);  // dir toggle in IDLE
    add(0, 0, 2'b00, 2'b00, 2'b00, 2'b01, 2'b00, 2'b00, 2'b00);
    add(0, 0, 2'b00, 2'b01, 2'b00, 2'b01, 2'b01, 2'b00, 2'b00);  // RUN toward limit
    add(0, 0, 2'b00, 2'b00, 2'b00, 2'b01, 2'b01, 2'b00, 2'b00);
    add(0, 0, 2'b00, 2'b00, 2'b01, 2'b01, 2'b00, 2'b01, 2'b00);  // limit -> LIMIT_HOLD
    add(0, 0, 2'b00, 2'b01, 2'b01, 2'b01, 2'b00, 2'b01, 2'b00);  // run ignored in hold
    add(0, 0, 2'b00, 2'b00, 2'b01, 2'b01, 2'b00, 2'b01, 2'b00);
    add(0, 0, 2'b01, 2'b00, 2'b01, 2'b00, 2'b00, 2'b01, 2'b00);  // dir flips, still held
    add(0, 0, 2'b00, 2'b00, 2'b01, 2'b00, 2'b00, 2'b00, 2'b00);  // released to IDLE
    add(0, 0, 2'b00, 2'b01, 2'b01, 2'b00, 2'b01, 2'b00, 2'b00);  // run away from closed limit
    add(0, 0, 2'b00, 2'b00, 2'b01, 2'b00, 2'b01, 2'b00, 2'b00);
    add(0, 0, 2'b00, 2'b01, 2'b01, 2'b00, 2'b00, 2'b00, 2'b00);
    add(0, 0, 2'b00, 2'b00, 2'b00, 2'b00, 2'b00, 2'b00, 2'b00);
    add(0, 0, 2'b00, 2'b00, 2'b01, 2'b00, 2'b00, 2'b00, 2'b00);
    add(0, 0, 2'b01, 2'b01, 2'b01, 2'b01, 2'b00, 2'b00, 2'b00);  // same-cycle dir+run: blocked
    add(0, 0, 2'b00, 2'b00, 2'b01, 2'b01, 2'b00, 2'b00, 2'b00);
    add(0, 0, 2'b00, 2'b00, 2'b00, 2'b01, 2'b00, 2'b00, 2'b00);
    add(0, 0, 2'b00, 2'b10, 2'b00, 2'b01, 2'b10, 2'b00, 2'b00);  // axis 1 alone
    add(0, 1, 2'b00, 2'b00, 2'b00, 2'b01, 2'b10, 2'b00, 2'b00);
    add(0, 0, 2'b00, 2'b10, 2'b00, 2'b01, 2'b00, 2'b00, 2'b00);
    add(0, 0, 2'b00, 2'b00, 2'b00, 2'b01, 2'b00, 2'b00, 2'b00);

    foreach (vecs[i]) begin
      rst           = vecs[i].rst;
      bus.step_tick = vecs[i].tick;
      bus.dir_btn   = vecs[i].dbtn;
      bus.run_btn   = vecs[i].rbtn;
      bus.limit     = vecs[i].lim;
      cyc();
      chk_all($sformatf("vec%0d", i), vecs[i].e_dir, vecs[i].e_en, vecs[i].e_lh, vecs[i].e_to);
    end
    bus.step_tick = 1'b0;
    bus.dir_btn   = 2'b00;
    bus.run_btn   = 2'b00;
    bus.limit     = 2'b00;

    // Timeout after five ticks, limit ignored in TIMEOUT, ack then restart.
    bus.run_btn = 2'b01; cyc(); bus.run_btn = 2'b00; cyc();
    chk_all("to_start", 2'b01, 2'b01, 2'b00, 2'b00);
    for (int k = 0; k < 4; k++) pulse_tick();
    chk_all("to_4ticks", 2'b01, 2'b01, 2'b00, 2'b00);
    pulse_tick();
    chk_all("to_5ticks", 2'b01, 2'b00, 2'b00, 2'b01);
    bus.limit = 2'b01; cyc();
    chk_all("to_limit", 2'b01, 2'b00, 2'b00, 2'b01);
    bus.limit = 2'b00; cyc();
    bus.run_btn = 2'b01; cyc();
    chk_all("to_ack", 2'b01, 2'b00, 2'b00, 2'b00);
    bus.run_btn = 2'b00; cyc();
    bus.run_btn = 2'b01; cyc();
    chk_all("to_restart", 2'b01, 2'b01, 2'b00, 2'b00);
    bus.run_btn = 2'b00; cyc();

    // Direction toggle mid-run clears the step count.
    for (int k = 0; k < 3; k++) pulse_tick();
    bus.dir_btn = 2'b01; cyc();
    chk_all("clr_toggle", 2'b00, 2'b01, 2'b00, 2'b00);
    bus.dir_btn = 2'b00; cyc();
    for (int k = 0; k < 4; k++) pulse_tick();
    chk_all("clr_4ticks", 2'b00, 2'b01, 2'b00, 2'b00);
    pulse_tick();
    chk_all("clr_5ticks", 2'b00, 2'b00, 2'b00, 2'b01);
    bus.run_btn = 2'b01; cyc(); bus.run_btn = 2'b00; cyc();
    chk_all("clr_ack", 2'b00, 2'b00, 2'b00, 2'b00);

    // Button held through reset produces no edge.
    bus.run_btn = 2'b10;
    rst = 1'b1; cyc();
    rst = 1'b0; cyc();
    chk_all("hold_rst", 2'b00, 2'b00, 2'b00, 2'b00);
    bus.run_btn = 2'b00; cyc();
    chk_all("hold_release", 2'b00, 2'b00, 2'b00, 2'b00);

    // Reset mid-run on both axes.
    bus.run_btn = 2'b11; cyc(); bus.run_btn = 2'b00;
    chk_all("both_run", 2'b00, 2'b11, 2'b00, 2'b00);
    bus.dir_btn = 2'b10; cyc(); bus.dir_btn = 2'b00;
    chk_all("both_dir", 2'b10, 2'b11, 2'b00, 2'b00);
    rst = 1'b1; cyc();
    chk_all("mid_rst", 2'b00, 2'b00, 2'b00, 2'b00);
    rst = 1'b0; cyc();

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
